// File: rtl/dsq_pair_packer.sv
// -----------------------------------------------------------------------------
// dsq_pair_packer
//
// Purpose:
//   Upstream feeder for the DSQ custom instruction. Each accepted 8-bit
//   sample x is paired with x_d, the sample accepted LAG acceptances earlier.
//   Two consecutive pairs are packed into one 32-bit operand
//   {x1, x1_d, x2, x2_d} and queued in a small FIFO. The CPU pops the words
//   and issues them as rs1 to the DSQ op.
//
// Parameters:
//   LAG    delay between a sample and its partner, in accepted samples (1..16)
//   DEPTH  output FIFO depth in 32-bit words (power of two, >= 2)
//
// Ports:
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset
//   s_valid  sample valid
//   s_ready  sample accepted when s_valid && s_ready
//   s_data   unsigned 8-bit sample
//   flush    single-cycle end-of-block pulse (wins over s_valid)
//   m_valid  FIFO head word valid
//   m_ready  consumer pops the head when m_valid && m_ready
//   m_data   packed head word, 0 when the FIFO is empty
//   level    FIFO occupancy in words
//
// Build option:
//   DSQ_PACK_PAD_EN  when defined, a flush that catches a pending half word
//                    emits it as {hi, 8'h00, 8'h00} (zero diff, so the DSQ
//                    sum is unaffected). When undefined the half word is
//                    dropped.
// -----------------------------------------------------------------------------
module dsq_pair_packer #(
  parameter int LAG   = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [7:0]                 s_data,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [31:0]                m_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [7:0]    dly_reg [LAG];
  logic [7:0]    x_d;

  logic          phase_reg;
  logic [15:0]   hi_reg;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic [LW-1:0] count_next;

  logic          full;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   push_data;
  logic          pad_pend;
  logic          pad_fire;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // full is registered occupancy, so a pop in this cycle does not raise
  // s_ready until the next cycle. resetn gates ready low while in reset.
  assign full    = (count_reg == LW'(DEPTH));
  assign s_ready = resetn && !full && !flush && !pad_pend;
  assign accept  = s_valid && s_ready;

  assign m_valid = (count_reg != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? mem[rd_ptr_reg] : 32'h0;
  assign level   = count_reg;

  // ---------------------------------------------------------------------------
  // Delay line: LAG-deep shift register, advances only on an accepted sample,
  // cleared by flush so the first LAG samples of a block pair with zero.
  // ---------------------------------------------------------------------------
  assign x_d = dly_reg[LAG-1];

  generate
    for (genvar gi = 0; gi < LAG; gi++) begin : g_dly
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          dly_reg[gi] <= 8'h00;
        end else if (flush) begin
          dly_reg[gi] <= 8'h00;
        end else if (accept) begin
          if (gi == 0) begin
            dly_reg[gi] <= s_data;
          end else begin
            dly_reg[gi] <= dly_reg[(gi > 0) ? gi - 1 : 0];
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Packing phase and half-word register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_reg <= 1'b0;
    end else if (flush) begin
      phase_reg <= 1'b0;
    end else if (accept) begin
      phase_reg <= ~phase_reg;
    end
  end

  // hi is only written by a phase-0 accept; while a pad word is waiting for
  // room no sample can be accepted, so hi still holds the pad's upper half.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_reg <= 16'h0000;
    end else if (accept && !phase_reg) begin
      hi_reg <= {s_data, x_d};
    end
  end

  // ---------------------------------------------------------------------------
  // Pad handling for a half word caught by flush
  // ---------------------------------------------------------------------------
`ifdef DSQ_PACK_PAD_EN
  logic pad_pend_reg;

  // The pad goes out in the flush cycle if there is room, otherwise it is
  // parked and pushed on the first cycle whose registered full is low.
  assign pad_fire = !full && (pad_pend_reg || (flush && phase_reg));
  assign pad_pend = pad_pend_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pad_pend_reg <= 1'b0;
    end else if (pad_fire) begin
      pad_pend_reg <= 1'b0;
    end else if (flush && phase_reg) begin
      pad_pend_reg <= 1'b1;
    end
  end
`else
  assign pad_fire = 1'b0;
  assign pad_pend = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO write source select. Pad and sample pushes never coincide because
  // s_ready is low during flush and while a pad is pending; the pad still
  // takes precedence in the select.
  // ---------------------------------------------------------------------------
  always_comb begin
    push      = 1'b0;
    push_data = 32'h0;
    if (pad_fire) begin
      push      = 1'b1;
      push_data = {hi_reg, 16'h0000};
    end else if (accept && phase_reg) begin
      push      = 1'b1;
      push_data = {hi_reg, s_data, x_d};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers. Storage is not reset; m_data is masked by
  // m_valid so stale contents never show after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + LW'(1);
      2'b01:   count_next = count_reg - LW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_dsq_pair_packer.sv
// -----------------------------------------------------------------------------
// tb_dsq_pair_packer
//
// Self-checking bench for dsq_pair_packer. One instance with LAG=1/DEPTH=4
// runs a per-cycle vector table plus hand-written flush/reset sequences; a
// second instance with LAG=2 checks partner selection at a longer lag.
// Expected words are hand-computed. Expectations that depend on the
// DSQ_PACK_PAD_EN build option are selected by PAD.
// -----------------------------------------------------------------------------
module tb_dsq_pair_packer;

`ifdef DSQ_PACK_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;

  logic        s_valid, s_ready, flush, m_valid, m_ready;
  logic [7:0]  s_data;
  logic [31:0] m_data;
  logic [2:0]  level;

  logic        s_valid2, s_ready2, flush2, m_valid2, m_ready2;
  logic [7:0]  s_data2;
  logic [31:0] m_data2;
  logic [2:0]  level2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsq_pair_packer #(.LAG(1), .DEPTH(4)) u_dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level)
  );

  dsq_pair_packer #(.LAG(2), .DEPTH(4)) u_dut2 (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2), .flush(flush2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .level(level2)
  );

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        fl;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic [2:0]  e_lv;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  task automatic add_vec(input logic sv, input logic [7:0] sd, input logic fl,
                         input logic mr, input logic e_sr, input logic e_mv,
                         input logic [31:0] e_md, input int e_lv);
    vec_t v;
    v.sv = sv; v.sd = sd; v.fl = fl; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_lv = 3'(e_lv);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: returns on the falling edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1; s_valid = 1'b0;
    #1;
    tick();
    flush = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d;
    #1;
    while (!s_ready && n < 50) begin
      tick(); #1; n++;
    end
    check($sformatf("send %h accepted", d), 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  // Pop every word in exp_q in order, comparing each head word.
  task automatic drain(input string tag);
    logic [31:0] w;
    int n;
    m_ready = 1'b1;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      n = 0;
      #1;
      while (!m_valid && n < 20) begin
        tick(); #1; n++;
      end
      check({tag, " m_valid"}, 32'(m_valid), 32'd1);
      check({tag, " m_data"}, m_data, w);
      tick();
    end
    m_ready = 1'b0;
    #1;
    check({tag, " empty level"}, 32'(level), 32'd0);
    check({tag, " empty m_valid"}, 32'(m_valid), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp2 [3];
    int k;

    resetn = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; flush = 1'b0; m_ready = 1'b0;
    s_valid2 = 1'b0; s_data2 = 8'h00; flush2 = 1'b0; m_ready2 = 1'b1;

    // ---------------- vector table (LAG=1 instance) ----------------
    // T1: 10,7,3,9 with m_ready=1
    add_vec(1, 8'h0A, 0, 1, 1, 0, 32'h0, 0);
    add_vec(1, 8'h07, 0, 1, 1, 0, 32'h0, 0);
    add_vec(1, 8'h03, 0, 1, 1, 1, 32'h0A00_070A, 1);
    add_vec(1, 8'h09, 0, 1, 1, 0, 32'h0, 0);
    add_vec(0, 8'h00, 0, 1, 1, 1, 32'h0307_0903, 1);
    add_vec(0, 8'h00, 0, 1, 1, 0, 32'h0, 0);
    add_vec(0, 8'h00, 1, 0, 0, 0, 32'h0, 0);          // flush, phase=0
    // T3: fill with m_ready=0
    add_vec(1, 8'h01, 0, 0, 1, 0, 32'h0, 0);
    add_vec(1, 8'h02, 0, 0, 1, 0, 32'h0, 0);
    add_vec(1, 8'h03, 0, 0, 1, 1, 32'h0100_0201, 1);
    add_vec(1, 8'h04, 0, 0, 1, 1, 32'h0100_0201, 1);
    add_vec(1, 8'h05, 0, 0, 1, 1, 32'h0100_0201, 2);
    add_vec(1, 8'h06, 0, 0, 1, 1, 32'h0100_0201, 2);
    add_vec(1, 8'h07, 0, 0, 1, 1, 32'h0100_0201, 3);
    add_vec(1, 8'h08, 0, 0, 1, 1, 32'h0100_0201, 3);
    add_vec(1, 8'h09, 0, 0, 0, 1, 32'h0100_0201, 4);  // full, stalled
    add_vec(1, 8'h09, 0, 0, 0, 1, 32'h0100_0201, 4);
    add_vec(1, 8'h09, 0, 1, 0, 1, 32'h0100_0201, 4);  // pop: ready stays low
    add_vec(1, 8'h09, 0, 0, 1, 1, 32'h0302_0403, 3);  // ready next cycle
    add_vec(1, 8'h0A, 0, 0, 1, 1, 32'h0302_0403, 3);
    add_vec(0, 8'h00, 0, 0, 0, 1, 32'h0302_0403, 4);
    add_vec(0, 8'h00, 0, 1, 0, 1, 32'h0302_0403, 4);
    add_vec(0, 8'h00, 0, 1, 1, 1, 32'h0504_0605, 3);
    add_vec(0, 8'h00, 0, 1, 1, 1, 32'h0706_0807, 2);
    add_vec(0, 8'h00, 0, 1, 1, 1, 32'h0908_0A09, 1);
    add_vec(0, 8'h00, 0, 1, 1, 0, 32'h0, 0);
    add_vec(0, 8'h00, 1, 0, 0, 0, 32'h0, 0);          // flush clears delay
    // T4: 5,6,7 then flush with s_valid high
    add_vec(1, 8'h05, 0, 0, 1, 0, 32'h0, 0);
    add_vec(1, 8'h06, 0, 0, 1, 0, 32'h0, 0);
    add_vec(1, 8'h07, 0, 0, 1, 1, 32'h0500_0605, 1);
    add_vec(1, 8'h08, 1, 0, 0, 1, 32'h0500_0605, 1);  // 8 must be dropped
    add_vec(1, 8'h09, 0, 0, 1, 1, 32'h0500_0605, PAD ? 2 : 1);
    add_vec(1, 8'h0B, 0, 0, 1, 1, 32'h0500_0605, PAD ? 2 : 1);
    add_vec(0, 8'h00, 0, 1, 1, 1, 32'h0500_0605, PAD ? 3 : 2);
    add_vec(0, 8'h00, 0, 1, 1, 1, PAD ? 32'h0706_0000 : 32'h0900_0B09, PAD ? 2 : 1);
    add_vec(0, 8'h00, 0, 1, 1, PAD, PAD ? 32'h0900_0B09 : 32'h0, PAD ? 1 : 0);
    add_vec(0, 8'h00, 0, 1, 1, 0, 32'h0, 0);

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    #1;
    check("reset s_ready", 32'(s_ready), 32'd0);
    check("reset m_valid", 32'(m_valid), 32'd0);
    check("reset m_data", m_data, 32'h0);
    check("reset level", 32'(level), 32'd0);
    resetn = 1'b1;
    #1;
    check("post-reset s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);

    // ---------------- T2: LAG=2 instance ----------------
    exp2[0] = 32'h0100_0200;
    exp2[1] = 32'h0301_0402;
    exp2[2] = 32'h0503_0604;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      s_valid2 = (i < 6);
      s_data2  = 8'(i + 1);
      #1;
      if (i < 6) check($sformatf("t2 cyc%0d s_ready", i), 32'(s_ready2), 32'd1);
      check($sformatf("t2 cyc%0d m_valid", i), 32'(m_valid2),
            32'((i == 2) || (i == 4) || (i == 6)));
      if (m_valid2 && k < 3) begin
        check($sformatf("t2 word%0d", k), m_data2, exp2[k]);
        k++;
      end
      tick();
    end
    s_valid2 = 1'b0;
    check("t2 word count", 32'(k), 32'd3);

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      s_valid = vecs[i].sv; s_data = vecs[i].sd;
      flush = vecs[i].fl;   m_ready = vecs[i].mr;
      #1;
      check($sformatf("row%0d s_ready", i), 32'(s_ready), 32'(vecs[i].e_sr));
      check($sformatf("row%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mv));
      check($sformatf("row%0d m_data", i), m_data, vecs[i].e_md);
      check($sformatf("row%0d level", i), 32'(level), 32'(vecs[i].e_lv));
      tick();
    end
    s_valid = 1'b0; flush = 1'b0; m_ready = 1'b0;

    // ---------------- T5: flush with a half word pending, FIFO filling ----
    pulse_flush();
    for (int i = 0; i < 7; i++) send(8'(8'h11 + i));
    #1;
    check("t5 level before flush", 32'(level), 32'd3);
    flush = 1'b1; s_valid = 1'b1; s_data = 8'h18;
    #1;
    check("t5 flush-cycle s_ready", 32'(s_ready), 32'd0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    #1;
    check("t5 level after flush", 32'(level), PAD ? 32'd4 : 32'd3);
    check("t5 s_ready after flush", 32'(s_ready), PAD ? 32'd0 : 32'd1);
    if (PAD) begin
      tick(); #1;
      check("t5 s_ready held", 32'(s_ready), 32'd0);
      m_ready = 1'b1;
      #1;
      check("t5 pop-cycle s_ready", 32'(s_ready), 32'd0);
      check("t5 pop-cycle m_data", m_data, 32'h1100_1211);
      tick();
      m_ready = 1'b0;
      #1;
      check("t5 after pop s_ready", 32'(s_ready), 32'd1);
      check("t5 after pop level", 32'(level), 32'd3);
      tick();
    end else begin
      tick();
    end
    send(8'h18);
    send(8'h19);
    #1;
    check("t5 level full", 32'(level), 32'd4);
    tick();
    if (!PAD) exp_q.push_back(32'h1100_1211);
    exp_q.push_back(32'h1312_1413);
    exp_q.push_back(32'h1514_1615);
    if (PAD) exp_q.push_back(32'h1716_0000);
    exp_q.push_back(32'h1800_1918);
    drain("t5");

    // ---------------- T6: async reset mid-stream ----------------
    for (int i = 0; i < 5; i++) send(8'(8'h31 + i));
    #1;
    check("t6 level before reset", 32'(level), 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    check("t6 reset m_valid", 32'(m_valid), 32'd0);
    check("t6 reset level", 32'(level), 32'd0);
    check("t6 reset m_data", m_data, 32'h0);
    check("t6 reset s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    send(8'h21);
    send(8'h22);
    #1;
    check("t6 level", 32'(level), 32'd1);
    check("t6 m_valid", 32'(m_valid), 32'd1);
    check("t6 first word", m_data, 32'h2100_2221);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
